prince_mask_shell: RTL and testbench
====================================

// Module: prince_mask_shell
// PURPOSE
// - Front/back-end shell around the masked round-based PRINCE core (d=1, two shares).
// - Upstream: accepts unmasked plaintext/key over valid/ready, splits the plaintext into two
//   shares, drives the core's go/Dec_EncBar/key/PRNG inputs and waits for done.
// - Downstream: recombines out_share0^out_share1 and presents the result over valid/ready.
// - Owns the 288-bit fresh-randomness source (prince_prng) that feeds the core every cycle.
// PARAMETERS
// - TIMEOUT    64         max cycles in RUN before err_timeout; counter width $clog2(TIMEOUT+1)
// - SEED_INIT  288'h...1  per-lane LFSR reset value, nine 32-bit lanes; no lane may be zero
// PORTS
// - clk          in   1    system clock, rising edge
// - reset        in   1    asynchronous, active-high
// - in_valid     in   1    plaintext/key request valid
// - in_ready     out  1    shell can accept a request
// - in_data      in   64   unmasked plaintext (or ciphertext when in_dec=1)
// - in_key       in   128  PRINCE key k0||k1
// - in_dec       in   1    1 = decrypt, 0 = encrypt
// - seed_valid   in   1    reload PRNG lanes from seed (honoured in IDLE only)
// - seed         in   288  PRNG reseed value, lane i = seed[32i+31:32i]
// - out_valid    out  1    result valid
// - out_ready    in   1    consumer accepts result
// - out_data     out  64   unmasked result
// - err_timeout  out  1    sticky: core failed to raise done within TIMEOUT cycles
// - core_go      out  1    one-cycle start pulse to core
// - core_dec     out  1    registered in_dec, drives core Dec_EncBar
// - core_key     out  128  registered key, stable from START until return to IDLE
// - core_prng    out  288  fresh randomness, new value every cycle
// - core_share0  out  64   registered share 0 = in_data ^ mask
// - core_share1  out  64   registered share 1 = mask
// - core_sh0_in  in   64   core out_share0
// - core_sh1_in  in   64   core out_share1
// - core_done    in   1    core done (level or pulse; first high cycle in RUN counts)
// BEHAVIOUR
// - Reset: state=IDLE; in_ready=1, out_valid=0, out_data=0, err_timeout=0, core_go=0, core_dec=0,
//   core_key/core_share0/core_share1=0, PRNG lanes=SEED_INIT, timeout counter=0.
// - FSM IDLE -> START -> RUN -> OUT -> IDLE.
// - IDLE: in_ready = !seed_valid (reseed has priority). Accept when in_valid&&in_ready:
//   mask = core_prng[63:0] of that cycle; latch share0=in_data^mask, share1=mask, key, dec; go START.
// - START: core_go=1 for exactly this cycle; clear timeout counter; -> RUN.
// - RUN: count cycles; first cycle core_done=1 -> out_data <= core_sh0_in^core_sh1_in, -> OUT.
//   Counter reaching TIMEOUT without done -> err_timeout<=1, out_data<=0, -> OUT. Done and
//   timeout in the same cycle: done wins, no error.
// - OUT: out_valid=1, out_data held stable until out_ready; on handshake -> IDLE, out_valid=0
//   next cycle. Latency in_valid accept -> out_valid = 2 + core cycles to done.
// - Back-to-back: no accept in the same cycle as the OUT handshake (in_ready=0 outside IDLE).
// - err_timeout cleared only by reset; shell keeps operating after it.
// - PRNG: each lane a 32-bit Galois LFSR (taps 32,22,2,1) advancing every cycle; seed_valid in
//   IDLE loads lanes, a zero lane is replaced by the SEED_INIT lane. seed_valid outside IDLE ignored.
// - Unmasked in_data is never held in a register; only shares are registered.
// - Reset mid-operation: immediate return to IDLE, any in-flight result discarded.
// STRUCTURE
// - Package prince_pkg: state enum (IDLE, START, RUN, OUT), LFSR tap constant, lane count 9,
//   lane width 32, SEED_INIT default.
// - Sub-module prince_prng (clk, reset, load, seed, prng[287:0]): nine LFSR lanes + zero guard.
// - Top: FSM, timeout counter, share/key/result registers, core wiring.
// TESTING
// - Reset then in_data=0x0000000000000000, key=0, enc, core model done after 12 cycles ->
//   one core_go pulse, out_data=0x818665aa0d02dfda, out_valid after 14 cycles.
// - Same vector decrypt (in_dec=1, in_data=0x818665aa0d02dfda) -> out_data=0x0000000000000000.
// - Check core_share0^core_share1==in_data and core_share1 differs across two requests.
// - Hold out_ready=0 for 10 cycles -> out_valid and out_data stable, in_ready=0 throughout.
// - Core never asserts done -> err_timeout=1 after 64 RUN cycles, out_data=0, sticky until reset.
// - seed_valid with in_valid in IDLE, seed lane 3 = 0 -> request not accepted that cycle,
//   lane 3 takes SEED_INIT value; assert reset mid-RUN -> IDLE, out_valid=0.

Source files
------------

// File: rtl/prince_pkg.sv
// Shared types and constants for the masked PRINCE shell: FSM states and PRNG lane geometry.
// The Galois LFSR step lives here so that every lane uses the same polynomial.
package prince_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        OUT
    } state_t;

    localparam int unsigned LANES  = 9;
    localparam int unsigned LANE_W = 32;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [LANE_W-1:0] LFSR_TAPS = 32'h8020_0003;

    localparam logic [LANES*LANE_W-1:0] SEED_INIT_DEF = {
        32'h6A09_E667, 32'hBB67_AE85, 32'h3C6E_F372,
        32'hA54F_F53A, 32'h510E_527F, 32'h9B05_688C,
        32'h1F83_D9AB, 32'h5BE0_CD19, 32'h0000_0001
    };

    function automatic logic [LANE_W-1:0] lfsr_step(input logic [LANE_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/prince_prng.sv
// Fresh-randomness source for the masked core: nine independent 32-bit Galois LFSR lanes
// that advance every cycle, with a reseed port that never lets a lane become all-zero.
module prince_prng
    import prince_pkg::*;
#(
    parameter logic [LANES*LANE_W-1:0] SEED_INIT = SEED_INIT_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [LANES*LANE_W-1:0]   seed,
    output logic [LANES*LANE_W-1:0]   prng
);

    logic [LANES-1:0][LANE_W-1:0] lanes;

    // An all-zero lane would lock up, so it falls back to its reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lanes <= SEED_INIT;
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (load) begin
                    if (seed[i*LANE_W +: LANE_W] == '0) begin
                        lanes[i] <= SEED_INIT[i*LANE_W +: LANE_W];
                    end else begin
                        lanes[i] <= seed[i*LANE_W +: LANE_W];
                    end
                end else begin
                    lanes[i] <= lfsr_step(lanes[i]);
                end
            end
        end
    end

    assign prng = lanes;

endmodule

// File: rtl/prince_mask_shell.sv
// Shell around the two-share masked PRINCE core: masks requests into shares, sequences the core,
// recombines its output shares, and guards against a core that never finishes.
module prince_mask_shell
    import prince_pkg::*;
#(
    parameter int unsigned             TIMEOUT   = 64,
    parameter logic [LANES*LANE_W-1:0] SEED_INIT = SEED_INIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    input  logic [127:0]  in_key,
    input  logic          in_dec,
    input  logic          seed_valid,
    input  logic [287:0]  seed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_data,
    output logic          err_timeout,
    output logic          core_go,
    output logic          core_dec,
    output logic [127:0]  core_key,
    output logic [287:0]  core_prng,
    output logic [63:0]   core_share0,
    output logic [63:0]   core_share1,
    input  logic [63:0]   core_sh0_in,
    input  logic [63:0]   core_sh1_in,
    input  logic          core_done
);

    localparam int unsigned    CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          prng_load;
    logic          tmo_hit;

    assign accept    = in_valid && in_ready;
    assign prng_load = seed_valid && (state == IDLE);
    assign tmo_hit   = (cnt == CNT_LAST);

    prince_prng #(
        .SEED_INIT (SEED_INIT)
    ) u_prng (
        .clk   (clk),
        .reset (reset),
        .load  (prng_load),
        .seed  (seed),
        .prng  (core_prng)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        core_go    = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !seed_valid;
                if (in_valid && !seed_valid) begin
                    state_next = START;
                end
            end
            START: begin
                core_go    = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (core_done || tmo_hit) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Only the shares are stored; the plaintext itself never lands in a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_share0 <= '0;
            core_share1 <= '0;
            core_key    <= '0;
            core_dec    <= 1'b0;
            cnt         <= '0;
            out_data    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (accept) begin
                core_share0 <= in_data ^ core_prng[63:0];
                core_share1 <= core_prng[63:0];
                core_key    <= in_key;
                core_dec    <= in_dec;
            end
            if (state == START) begin
                cnt <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + CW'(1);
            end
            // A done arriving on the last allowed cycle still counts as success.
            if (state == RUN) begin
                if (core_done) begin
                    out_data <= core_sh0_in ^ core_sh1_in;
                end else if (tmo_hit) begin
                    out_data    <= '0;
                    err_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prince_mask_shell.sv
// Randomised scoreboard bench for prince_mask_shell with a behavioural core stand-in
// (known-answer table plus a keyed toy permutation) and an independent PRNG reference.
module tb_prince_mask_shell;
    import prince_pkg::*;

    typedef logic [287:0] w_t;

    localparam int unsigned TMO = 64;
    localparam logic [287:0] TB_SEED = {
        32'hC3A5_0F1E, 32'h1234_5678, 32'hDEAD_BEEF,
        32'h0BAD_F00D, 32'h7777_1111, 32'hCAFE_BABE,
        32'h8BAD_F00D, 32'h0F0F_1E1E, 32'h0000_0001
    };

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic [127:0]  in_key;
    logic          in_dec;
    logic          seed_valid;
    logic [287:0]  seed;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic          err_timeout;
    logic          core_go;
    logic          core_dec;
    logic [127:0]  core_key;
    logic [287:0]  core_prng;
    logic [63:0]   core_share0;
    logic [63:0]   core_share1;
    logic [63:0]   core_sh0_in;
    logic [63:0]   core_sh1_in;
    logic          core_done;

    always #5 clk = ~clk;

    prince_mask_shell #(
        .TIMEOUT   (TMO),
        .SEED_INIT (TB_SEED)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_key      (in_key),
        .in_dec      (in_dec),
        .seed_valid  (seed_valid),
        .seed        (seed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .err_timeout (err_timeout),
        .core_go     (core_go),
        .core_dec    (core_dec),
        .core_key    (core_key),
        .core_prng   (core_prng),
        .core_share0 (core_share0),
        .core_share1 (core_share1),
        .core_sh0_in (core_sh0_in),
        .core_sh1_in (core_sh1_in),
        .core_done   (core_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input w_t act, input w_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Published PRINCE known-answer vectors, key = k0||k1
    logic [63:0]  kat_pt  [5] = '{64'h0000000000000000, 64'hffffffffffffffff, 64'h0000000000000000,
                                 64'h0000000000000000, 64'h0123456789abcdef};
    logic [127:0] kat_key [5] = '{128'h0, 128'h0, {64'hffffffffffffffff, 64'h0},
                                 {64'h0, 64'hffffffffffffffff}, {64'h0, 64'hfedcba9876543210}};
    logic [63:0]  kat_ct  [5] = '{64'h818665aa0d02dfda, 64'h604ae6ca03c20ada, 64'h9fb51935fc3df524,
                                 64'h78a54cbe737bb7ef, 64'hae25ad3ca8fa9ccf};

    function automatic logic [63:0] ref_cipher(input logic [63:0] x, input logic [127:0] key,
                                               input logic dec);
        logic [63:0] t;
        logic [63:0] r;
        logic        hit;
        hit = 1'b0;
        r   = '0;
        for (int i = 0; i < 5; i++) begin
            if (!hit && kat_key[i] == key) begin
                if (!dec && kat_pt[i] == x) begin r = kat_ct[i]; hit = 1'b1; end
                if (dec && kat_ct[i] == x)  begin r = kat_pt[i]; hit = 1'b1; end
            end
        end
        if (!hit) begin
            if (!dec) begin
                t = x ^ key[127:64];
                r = {t[50:0], t[63:51]} ^ key[63:0];
            end else begin
                t = x ^ key[63:0];
                r = {t[12:0], t[63:13]} ^ key[127:64];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        int          taps [4] = '{32, 22, 2, 1};
        logic [31:0] m;
        m = '0;
        foreach (taps[i]) m[taps[i]-1] = 1'b1;
        return s[0] ? ((s >> 1) ^ m) : (s >> 1);
    endfunction

    // Independent PRNG reference; tb_load is raised only when the bench knows the shell is idle
    logic         tb_load;
    logic [287:0] prng_model;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            prng_model <= TB_SEED;
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (tb_load)
                    prng_model[32*i +: 32] <= (seed[32*i +: 32] == 32'h0) ? TB_SEED[32*i +: 32]
                                                                          : seed[32*i +: 32];
                else
                    prng_model[32*i +: 32] <= lfsr_next(prng_model[32*i +: 32]);
            end
        end
    end

    // Core stand-in: raises done 'delay' cycles after go (0 = never) with freshly re-masked result
    int          pend_delay = 0;
    int          core_cnt;
    logic        core_busy;
    logic [63:0] core_rnd;
    always @(negedge clk) core_rnd <= {$urandom(), $urandom()};
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_busy   <= 1'b0;
            core_cnt    <= 0;
            core_done   <= 1'b0;
            core_sh0_in <= '0;
            core_sh1_in <= '0;
        end else begin
            core_done <= 1'b0;
            if (core_go) begin
                core_busy   <= (pend_delay != 0);
                core_cnt    <= pend_delay;
                core_sh0_in <= ref_cipher(core_share0 ^ core_share1, core_key, core_dec) ^ core_rnd;
                core_sh1_in <= core_rnd;
            end else if (core_busy) begin
                if (core_cnt == 1) begin
                    core_done <= 1'b1;
                    core_busy <= 1'b0;
                end else begin
                    core_cnt <= core_cnt - 1;
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int bp_mode = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   cur_delay = 1;
    logic err_model = 1'b0;

    initial begin : monitor
        exp_t        e;
        logic        start_pend = 1'b0;
        logic        ov_seen    = 1'b0;
        logic        have_last  = 1'b0;
        int          go_cnt     = 0;
        logic [63:0] acc_data, acc_mask, last_mask;
        logic [127:0] acc_key;
        logic        acc_dec;
        logic        tmo;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                err_model  = 1'b0;
                start_pend = 1'b0;
                ov_seen    = 1'b0;
                go_cnt     = 0;
                continue;
            end
            chk("prng", core_prng, prng_model);
            if (out_valid) chk("in_ready_busy", w_t'(in_ready), w_t'(0));
            if (start_pend) begin
                chk("go_in_start", w_t'(core_go), w_t'(1));
                chk("share1_mask", w_t'(core_share1), w_t'(acc_mask));
                chk("share_xor", w_t'(core_share0 ^ core_share1), w_t'(acc_data));
                chk("core_key", w_t'(core_key), w_t'(acc_key));
                chk("core_dec", w_t'(core_dec), w_t'(acc_dec));
                if (have_last) chk("mask_differs", w_t'(core_share1 != last_mask), w_t'(1));
                last_mask  = acc_mask;
                have_last  = 1'b1;
                start_pend = 1'b0;
            end
            if (core_go) go_cnt++;
            if (out_valid && !ov_seen) begin
                ov_seen = 1'b1;
                if (sb.size() == 0) chk("unexpected_out", w_t'(1), w_t'(0));
                else chk("latency", w_t'(cyc - sb[0].acc_cyc), w_t'(sb[0].lat));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_handshake", w_t'(1), w_t'(0));
                end else begin
                    e = sb.pop_front();
                    chk("out_data", w_t'(out_data), w_t'(e.data));
                    chk("err_timeout", w_t'(err_timeout), w_t'(e.err));
                end
                chk("go_pulses", w_t'(go_cnt), w_t'(1));
                go_cnt  = 0;
                ov_seen = 1'b0;
            end
            if (in_valid && in_ready) begin
                tmo       = (cur_delay == 0) || (cur_delay > int'(TMO) - 1);
                e.data    = tmo ? 64'h0 : ref_cipher(in_data, in_key, in_dec);
                e.err     = err_model || tmo;
                e.lat     = tmo ? int'(TMO) + 1 : 2 + cur_delay;
                e.acc_cyc = cyc + 1;
                err_model = e.err;
                sb.push_back(e);
                pend_delay = cur_delay;
                acc_data   = in_data;
                acc_mask   = prng_model[63:0];
                acc_key    = in_key;
                acc_dec    = in_dec;
                start_pend = 1'b1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [63:0] d, input logic [127:0] k, input logic dc, input int dly);
        int n;
        cur_delay = dly;
        in_data   = d;
        in_key    = k;
        in_dec    = dc;
        in_valid  = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL accept_wait: in_ready never rose within %0d cycles", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = {$urandom(), $urandom()};
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 600) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", w_t'(sb.size()), w_t'(0));
    endtask

    logic [287:0] seed_val;
    int           n_wait;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_key     = '0;
        in_dec     = 1'b0;
        seed_valid = 1'b0;
        seed       = '0;
        tb_load    = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", w_t'(in_ready), w_t'(1));
        chk("rst_out_valid", w_t'(out_valid), w_t'(0));
        chk("rst_out_data", w_t'(out_data), w_t'(0));
        chk("rst_err", w_t'(err_timeout), w_t'(0));
        chk("rst_go", w_t'(core_go), w_t'(0));
        chk("rst_dec", w_t'(core_dec), w_t'(0));
        chk("rst_key", w_t'(core_key), w_t'(0));
        chk("rst_shares", w_t'({core_share0, core_share1}), w_t'(0));
        @(posedge clk);
        #1;

        send(64'h0, 128'h0, 1'b0, 12);
        drain();
        send(64'h818665aa0d02dfda, 128'h0, 1'b1, 12);
        drain();
        for (int i = 1; i < 5; i++) begin
            send(kat_pt[i], kat_key[i], 1'b0, int'($urandom_range(1, 15)));
            send(kat_ct[i], kat_key[i], 1'b1, int'($urandom_range(1, 15)));
        end
        drain();

        // Backpressure: result must sit still while the consumer stalls
        bp_mode = 2;
        @(posedge clk);
        #1;
        send(kat_pt[4], kat_key[4], 1'b0, 7);
        n_wait = 0;
        while (!out_valid && n_wait < 100) begin
            @(negedge clk);
            n_wait++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", w_t'(out_valid), w_t'(1));
            chk("hold_data", w_t'(out_data), w_t'(kat_ct[4]));
            chk("hold_in_ready", w_t'(in_ready), w_t'(0));
        end
        bp_mode = 0;
        drain();

        // Done on the last permitted RUN cycle beats the timeout
        send({$urandom(), $urandom()}, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 63);
        drain();

        bp_mode = 1;
        for (int i = 0; i < 20; i++) begin
            send({$urandom(), $urandom()}, {$urandom(), $urandom(), $urandom(), $urandom()},
                 1'($urandom_range(0, 1)), int'($urandom_range(1, 20)));
        end
        drain();
        bp_mode = 0;

        send({$urandom(), $urandom()}, 128'h1, 1'b0, 0);
        drain();
        send({$urandom(), $urandom()}, 128'h2, 1'b1, 64);
        drain();
        send(kat_pt[0], kat_key[0], 1'b0, 5);
        drain();
        chk("err_sticky", w_t'(err_timeout), w_t'(1));

        // Reseed in IDLE blocks the concurrent request; lane 3 is zero and must fall back
        for (int i = 0; i < 9; i++) seed_val[32*i +: 32] = $urandom() | 32'h1;
        seed_val[127:96] = 32'h0;
        seed       = seed_val;
        seed_valid = 1'b1;
        tb_load    = 1'b1;
        in_data    = kat_pt[1];
        in_key     = kat_key[1];
        in_dec     = 1'b0;
        in_valid   = 1'b1;
        @(negedge clk);
        chk("seed_blocks_accept", w_t'(in_ready), w_t'(0));
        @(posedge clk);
        #1;
        seed_valid = 1'b0;
        tb_load    = 1'b0;
        in_valid   = 1'b0;
        @(negedge clk);
        chk("lane3_guard", w_t'(core_prng[127:96]), w_t'(TB_SEED[127:96]));
        chk("lane0_seed", w_t'(core_prng[31:0]), w_t'(seed_val[31:0]));
        @(posedge clk);
        #1;
        send(kat_pt[1], kat_key[1], 1'b0, 9);

        // Reseed while busy must be ignored
        seed       = {9{$urandom()}};
        seed_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 seed_valid = 1'b0;
        drain();

        // Reset mid-RUN discards the in-flight request and clears the sticky error
        send({$urandom(), $urandom()}, 128'h3, 1'b0, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("pre_reset_err", w_t'(err_timeout), w_t'(1));
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", w_t'(in_ready), w_t'(1));
        chk("midrst_out_valid", w_t'(out_valid), w_t'(0));
        chk("midrst_err", w_t'(err_timeout), w_t'(0));
        chk("midrst_out_data", w_t'(out_data), w_t'(0));
        chk("midrst_go", w_t'(core_go), w_t'(0));
        @(posedge clk);
        #1;
        send(kat_pt[2], kat_key[2], 1'b0, 4);
        drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
